// File: rtl/int_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : int_pkg                                                       |
// | Purpose  : Shared types and limits for the multi-channel integrator      |
// |            cascade (int_mc / int_stage_mc).                              |
// | Contents : chan_w()  - channel index width, max(1, clog2(channels))      |
// |            sample_t  - {value, valid, chan} record passed stage to stage |
// |            MAX_CHANNELS, MAX_STAGES, MAX_WIDTH, MAX_CHW limits           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package int_pkg;

  localparam int MAX_CHANNELS = 16;
  localparam int MAX_STAGES   = 6;
  // The sample record is sized for the widest supported datapath and channel
  // index; each instance uses only the low WIDTH / CHW bits.
  localparam int MAX_WIDTH    = 64;
  localparam int MAX_CHW      = $clog2(MAX_CHANNELS);

  function automatic int chan_w(input int channels);
    if (channels <= 1) return 1;
    return $clog2(channels);
  endfunction

  typedef struct packed {
    logic [MAX_WIDTH-1:0] value;
    logic                 valid;
    logic [MAX_CHW-1:0]   chan;
  } sample_t;

endpackage
`default_nettype wire

// File: rtl/int_stage_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : int_stage_mc                                                  |
// | Purpose  : One multi-channel integrator stage. Holds one accumulator per |
// |            channel; a valid input for channel c does acc[c] += value and |
// |            emits the new acc[c] with its valid and channel one cycle     |
// |            later. clr zeroes every accumulator (a colliding sample then  |
// |            starts from zero). Wrap-around arithmetic, no saturation.     |
// | Ports    : clk, rst (sync, active-high), clr                             |
// |            src - incoming sample record                                  |
// |            dst - registered outgoing sample record                       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module int_stage_mc
  import int_pkg::*;
#(
  parameter int WIDTH    = 56,
  parameter int CHANNELS = 2,
  parameter int CHW      = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    clr,
  input  sample_t src,
  output sample_t dst
);

  logic [WIDTH-1:0] r_acc [CHANNELS];
  logic [WIDTH-1:0] r_out_value;
  logic             r_out_valid;
  logic [CHW-1:0]   r_out_chan;

  logic [WIDTH-1:0] w_in_value;
  logic [CHW-1:0]   w_in_chan;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_sum;
  logic             w_unused_src;

  assign w_in_value   = src.value[WIDTH-1:0];
  assign w_in_chan    = src.chan[CHW-1:0];
  assign w_unused_src = ^{src.value, src.chan};

  // Same-channel bypass: when the previous cycle produced a result for this
  // channel, that result register already equals the freshly written acc[c],
  // so it is used directly instead of going through the register-file mux.
  // r_out_valid guards against a stale output after a clr with no sample.
  always_comb begin
    w_base = r_acc[w_in_chan];
    if (r_out_valid && (r_out_chan == w_in_chan)) begin
      w_base = r_out_value;
    end
    if (clr) begin
      w_base = '0;
    end
    w_sum = w_base + w_in_value;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_acc[c] <= '0;
      end
      r_out_value <= '0;
      r_out_valid <= 1'b0;
      r_out_chan  <= '0;
    end else begin
      r_out_valid <= src.valid;
      if (clr) begin
        for (int c = 0; c < CHANNELS; c++) begin
          r_acc[c] <= '0;
        end
      end
      // Later assignment wins over the clear for the colliding channel.
      if (src.valid) begin
        r_acc[w_in_chan] <= w_sum;
        r_out_value      <= w_sum;
        r_out_chan       <= w_in_chan;
      end
    end
  end

  always_comb begin
    dst                  = '0;
    dst.value[WIDTH-1:0] = r_out_value;
    dst.valid            = r_out_valid;
    dst.chan[CHW-1:0]    = r_out_chan;
  end

endmodule
`default_nettype wire

// File: rtl/int_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : int_mc                                                        |
// | Purpose  : Multi-channel integrator cascade. Tracks the channel of each  |
// |            time-interleaved input sample, realigns on dfirst (flagging   |
// |            sync_err if the frame was out of step) and runs the samples   |
// |            through STAGES integrator stages. Latency = STAGES cycles.    |
// | Ports    : clk, rst (sync, active-high), clr (clear accumulators)        |
// |            d/dv/dfirst - input sample, valid, channel-0 marker           |
// |            q/qv/qch    - last-stage output, valid, channel               |
// |            sync_err    - pulse one cycle after an out-of-step dfirst     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module int_mc
  import int_pkg::*;
#(
  parameter  int WIDTH    = 56,
  parameter  int CHANNELS = 2,
  parameter  int STAGES   = 1,
  localparam int CHW      = chan_w(CHANNELS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             dv,
  input  logic             dfirst,
  output logic [WIDTH-1:0] q,
  output logic             qv,
  output logic [CHW-1:0]   qch,
  output logic             sync_err
);

  logic [CHW-1:0]         r_ich;
  logic                   r_sync_err;
  logic                   w_first;
  logic [CHW-1:0]         w_in_chan;
  logic [CHW-1:0]         w_ich_next;
  sample_t                w_head;
  sample_t [STAGES:0]     w_stage;
  logic                   w_unused_tail;

  always_comb begin
    w_first    = dv && dfirst;
    w_in_chan  = w_first ? '0 : r_ich;
    w_ich_next = (w_in_chan == CHW'(CHANNELS - 1)) ? '0 : (w_in_chan + CHW'(1));
  end

  // The counter only moves on valid samples, so idle gaps hold its position.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ich      <= '0;
      r_sync_err <= 1'b0;
    end else begin
      if (dv) begin
        r_ich <= w_ich_next;
      end
      r_sync_err <= w_first && (r_ich != '0);
    end
  end

  always_comb begin
    w_head                  = '0;
    w_head.value[WIDTH-1:0] = d;
    w_head.valid            = dv;
    w_head.chan[CHW-1:0]    = w_in_chan;
  end

  assign w_stage[0] = w_head;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    int_stage_mc #(
      .WIDTH    (WIDTH),
      .CHANNELS (CHANNELS),
      .CHW      (CHW)
    ) u_stage (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .src (w_stage[k]),
      .dst (w_stage[k+1])
    );
  end

  assign q             = w_stage[STAGES].value[WIDTH-1:0];
  assign qv            = w_stage[STAGES].valid;
  assign qch           = w_stage[STAGES].chan[CHW-1:0];
  assign sync_err      = r_sync_err;
  assign w_unused_tail = ^w_stage[STAGES];

endmodule
`default_nettype wire
